rotate_left_seq: RTL and testbench



---
 rtl/rotate_left_seq_pkg.sv | 18 +
 rtl/rotate_left_seq_if.sv | 25 ++
 rtl/rotate_left_seq.sv | 88 ++++++++
 tb/tb_rotate_left_seq.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/rotate_left_seq_pkg.sv
// Shared definitions for the iterative rotate-left ALU unit: state encoding,
// datapath widths and the rotate-by-one helper.
package rotate_left_seq_pkg;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [DATA_W-1:0] rotl1(input logic [DATA_W-1:0] value);
    return {value[DATA_W-2:0], value[DATA_W-1]};
  endfunction

endpackage

// File: rtl/rotate_left_seq_if.sv
// Start/done handshake, operands, result and flag bundle of the rotate-left unit.
interface rotate_left_seq_if;
  import rotate_left_seq_pkg::*;

  logic                          start;
  logic [DATA_W-1:0]             j;
  logic [CNT_W-1:0]              k;
  logic                          busy;
  logic                          done;
  logic [DATA_W-1:0]             result;
  logic                          Z;
  logic                          N;
  logic                          C;
  logic                          V;

  modport master (
    output start, j, k,
    input  busy, done, result, Z, N, C, V
  );

  modport slave (
    input  start, j, k,
    output busy, done, result, Z, N, C, V
  );
endinterface

// File: rtl/rotate_left_seq.sv
// Iterative 16-bit rotate-left: one bit position per clock under a start/done
// handshake, with the ALU Z/N/C/V flag set.
module rotate_left_seq
  import rotate_left_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  rotate_left_seq_if.slave   bus
);

  state_t            state_r;
  state_t            state_nxt;
  logic [DATA_W-1:0] work_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              kz_r;
  logic              load_s;
  logic              step_s;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state decode; start is only honoured outside ROT, and ROT exits at cnt == 1
  // so the counter never wraps.
  always_comb begin
    state_nxt = state_r;
    load_s    = 1'b0;
    step_s    = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (bus.start) begin
          load_s    = 1'b1;
          state_nxt = (bus.k == 4'd0) ? DONE : ROT;
        end else begin
          state_nxt = IDLE;
        end
      end
      ROT: begin
        step_s = 1'b1;
        if (cnt_r == 4'd1) begin
          state_nxt = DONE;
        end else begin
          state_nxt = ROT;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Working register, remaining-count and zero-amount flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_r <= 16'h0000;
      cnt_r  <= 4'd0;
      kz_r   <= 1'b0;
    end else if (load_s) begin
      work_r <= bus.j;
      cnt_r  <= bus.k;
      kz_r   <= (bus.k == 4'd0);
    end else if (step_s) begin
      work_r <= rotl1(work_r);
      cnt_r  <= cnt_r - 4'd1;
    end else begin
      work_r <= work_r;
      cnt_r  <= cnt_r;
      kz_r   <= kz_r;
    end
  end

  assign bus.busy   = (state_r == ROT);
  assign bus.done   = (state_r == DONE);
  assign bus.result = work_r;

  // Flags follow the shared ALU flag format; the bit last carried out of bit 15
  // lands in bit 0, so C is result[0] unless nothing was rotated.
  assign bus.Z = (work_r == 16'h0000);
  assign bus.N = work_r[DATA_W-1];
  assign bus.C = kz_r ? 1'b0 : work_r[0];
  assign bus.V = 1'b0;

endmodule

// File: tb/tb_rotate_left_seq.sv
// Self-checking bench for rotate_left_seq: directed handshake scenarios plus
// random operations checked against an arithmetic rotate model.
module tb_rotate_left_seq;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rotate_left_seq_if bus ();

  rotate_left_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_rot(input logic [15:0] a, input int n);
    int unsigned x;
    x = a;
    return 16'(((x << n) | (x >> (16 - n))) & 32'h0000_FFFF);
  endfunction

  // bit carried out last is the one originally at position 16-n
  function automatic logic ref_c(input logic [15:0] a, input int n);
    if (n == 0) return 1'b0;
    return a[16 - n];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] a, input logic [3:0] n);
    bus.start = 1'b1;
    bus.j     = a;
    bus.k     = n;
    tick();
    bus.start = 1'b0;
  endtask

  // Counts edges until done, checking busy duration and result/flags at done.
  task automatic wait_done(input string tag, input int edges,
                           input logic [15:0] a, input int n);
    int cnt;
    int busy_cnt;
    logic [15:0] r;
    cnt = 0;
    busy_cnt = 0;
    r = ref_rot(a, n);
    while (bus.done !== 1'b1 && cnt < 40) begin
      if (bus.busy === 1'b1) busy_cnt++;
      tick();
      cnt++;
    end
    chk({tag, "_latency"}, 32'(cnt), 32'(edges));
    chk({tag, "_busy"}, 32'(busy_cnt), 32'(edges));
    chk({tag, "_result"}, 32'(bus.result), 32'(r));
    chk({tag, "_flags"}, {28'd0, bus.Z, bus.N, bus.C, bus.V},
        {28'd0, (r == 16'h0000), r[15], ref_c(a, n), 1'b0});
  endtask

  task automatic check_drop(input string tag, input logic [15:0] held);
    tick();
    chk({tag, "_done_drop"}, 32'(bus.done), 32'd0);
    chk({tag, "_hold"}, 32'(bus.result), 32'(held));
  endtask

  initial begin
    int n;
    logic [15:0] a;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.j = 16'h0000;
    bus.k = 4'd0;
    #1 rst = 1'b1;
    #2;
    chk("reset_outputs", {bus.busy, bus.done, bus.result, bus.Z, bus.N, bus.C, bus.V},
        {1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0});
    tick();
    tick();
    rst = 1'b0;
    tick();

    issue(16'h8001, 4'd1);
    wait_done("t1", 1, 16'h8001, 1);
    chk("t1_result_abs", 32'(bus.result), 32'h0003);
    check_drop("t1", 16'h0003);

    issue(16'h1234, 4'd4);
    wait_done("t2", 4, 16'h1234, 4);
    chk("t2_result_abs", 32'(bus.result), 32'h2341);
    for (int i = 0; i < 10; i++) check_drop("t2_idle", 16'h2341);

    issue(16'h8000, 4'd0);
    wait_done("t3", 0, 16'h8000, 0);
    check_drop("t3", 16'h8000);

    issue(16'h0000, 4'd15);
    wait_done("t4a", 15, 16'h0000, 15);
    check_drop("t4a", 16'h0000);
    issue(16'h0001, 4'd15);
    wait_done("t4b", 15, 16'h0001, 15);
    chk("t4b_result_abs", 32'(bus.result), 32'h8000);
    check_drop("t4b", 16'h8000);

    // start pulsed mid-rotation must be ignored
    issue(16'h00F0, 4'd8);
    bus.start = 1'b1;
    bus.j = 16'hFFFF;
    bus.k = 4'd2;
    tick();
    bus.start = 1'b0;
    wait_done("t5", 7, 16'h00F0, 8);
    chk("t5_result_abs", 32'(bus.result), 32'hF000);
    // back-to-back start accepted in the DONE cycle
    issue(16'h0001, 4'd1);
    chk("t5_b2b_done_low", 32'(bus.done), 32'd0);
    wait_done("t5b", 1, 16'h0001, 1);
    chk("t5b_result_abs", 32'(bus.result), 32'h0002);
    check_drop("t5b", 16'h0002);

    // asynchronous reset in the middle of a rotation
    issue(16'h1234, 4'd8);
    tick();
    tick();
    chk("t6_busy_before", 32'(bus.busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("t6_async_reset", {bus.busy, bus.done, bus.result, bus.Z},
        {1'b0, 1'b0, 16'h0000, 1'b1});
    tick();
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) n++;
    end
    chk("t6_no_resume", 32'(n), 32'd0);
    issue(16'hA5C3, 4'd5);
    wait_done("t6_after", 5, 16'hA5C3, 5);

    for (int i = 0; i < 20; i++) begin
      a = 16'($urandom);
      n = int'($urandom_range(0, 15));
      issue(a, 4'(n));
      wait_done("rand", n, a, n);
      check_drop("rand", ref_rot(a, n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
